bridge_obi_arbiter: RTL and testbench
=====================================

Name: bridge_obi_arbiter

Overview:
- Shares the single OBI manager port into gr_heep_top (req/we/be/addr/wdata, gnt/rvalid/rdata) between two OBI requesters.
  - Requester 0: bridge2xheep, driven by the USB register path.
  - Requester 1: a second host-side agent, such as a memory-dump or trace engine.
- Arbitration is round-robin with a locked address phase.
- Response routing uses an in-order ID FIFO, so up to pMAX_OUTSTANDING transactions can be in flight.
- Sits in cw305_top between the requesters and gr_heep_top, in the heep_clk domain.

Parameters:
- pADDR_W, 32, OBI address width.
- pDATA_W, 32, OBI data width.
- pMAX_OUTSTANDING, 4, depth of the response-routing FIFO; must be a power of two and at least 2.

Ports:
- clk  in  1  heep_clk.
- reset_i  in  1  synchronous, active-high reset.
- s_req_i  in  2  request, per requester.
- s_we_i  in  2  write enable, per requester.
- s_be_i  in  2x4  byte enables.
- s_addr_i  in  2xpADDR_W  address.
- s_wdata_i  in  2xpDATA_W  write data.
- s_gnt_o  out  2  grant, per requester.
- s_rvalid_o  out  2  response valid, per requester.
- s_rdata_o  out  pDATA_W  read data, shared by both requesters; qualify with s_rvalid_o.
- m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o  out  manager address phase, to gr_heep_top.
- m_gnt_i, m_rvalid_i  in  1  manager grant and response valid.
- m_rdata_i  in  pDATA_W  manager read data.
- busy_o  out  1  high while the FIFO is non-empty or m_req_o is high.
- err_o  out  1  sticky flag: a response arrived with no outstanding entry.

Behaviour:
- Reset (reset_i sampled high at a clk edge):
  - FIFO emptied; round-robin pointer cleared to 0, so requester 0 has priority; lock cleared; err_o cleared.
  - All outputs are 0 while reset is held.
- Reset mid-transaction discards outstanding IDs. Responses that arrive afterwards are dropped and set err_o.
- Selection, in state IDLE (no lock):
  - One requester active: select it.
  - Both active: select the requester pointed to by the round-robin pointer.
- Address phase:
  - m_req_o = selected s_req && !fifo_full.
  - m_we/be/addr/wdata are muxed combinationally from the selected requester.
  - s_gnt_o[sel] = m_gnt_i && m_req_o; the other grant bit is 0.
- Lock:
  - If m_req_o is high and m_gnt_i is low, enter state LOCKED and hold sel until the handshake completes. The address phase must never switch requester mid-request.
  - LOCKED is left on the cycle after m_req_o && m_gnt_i.
- On each handshake (m_req_o && m_gnt_i):
  - Push sel into the FIFO.
  - Pointer becomes ~sel, so the other requester has priority next.
  - The same requester may be granted again next cycle if the other requester is idle.
- FIFO full: m_req_o is held low; the requester's req stays asserted per OBI rules and it is not granted.
- Response phase:
  - On m_rvalid_i, pop the FIFO head.
  - s_rvalid_o[head] = 1 in the same cycle (combinational, zero added latency).
  - s_rdata_o = m_rdata_i.
- FIFO empty with m_rvalid_i high: no s_rvalid_o asserted; err_o is set.
- Push and pop in the same cycle: allowed when the FIFO is full, because the pop frees the slot. m_req_o may be high in that case (full && m_rvalid_i counts as not-full).
- Count and pointer wrap modulo pMAX_OUTSTANDING.
- Count width is $clog2(pMAX_OUTSTANDING)+1.

Optional Feature:
- Macro BRIDGE_ARB_PERF_EN.
- Defined:
  - Adds ports perf_clr_i (in, 1) and perf_gnt0_o, perf_gnt1_o, perf_stall_o (out, 32 each).
  - perf_gnt0_o / perf_gnt1_o count handshakes per requester.
  - perf_stall_o counts cycles with any s_req high and no grant.
  - All counters saturate at 0xFFFFFFFF.
  - Counters clear on reset_i or perf_clr_i; perf_clr_i has priority over an increment in the same cycle.
- Undefined: these ports and counters do not exist, and the logic is otherwise identical.

Decomposition:
- Shared package bridge_obi_pkg holds:
  - the OBI width constants;
  - typedef obi_req_t {req, we, be, addr, wdata};
  - typedef obi_rsp_t {gnt, rvalid, rdata};
  - localparam ID_W.
- Sub-module bridge_obi_id_fifo: synchronous FIFO storing 1-bit IDs, with push/pop/full/empty/count and simultaneous push+pop support.

Test Plan:
- After reset, requester 0 writes 0xDEADBEEF to 0x0000_0100 with m_gnt_i high immediately.
  - m_req_o high in the same cycle; s_gnt_o = 2'b01; FIFO count = 1.
  - m_rvalid_i one cycle later → s_rvalid_o = 2'b01 and busy_o falls.
- Both requesters hold req for 4 transactions each, with gnt always high.
  - Grants alternate 0,1,0,1,…
  - Responses are returned in order with rdata 0x1..0x8; each is routed to the requester that issued it.
- Requester 0 is held with m_gnt_i low for 3 cycles while requester 1 also raises req.
  - sel stays 0 and m_addr_o stays stable for all 3 cycles; s_gnt_o[1] stays 0.
  - After the grant, requester 1 is granted next.
- Continuous grants with no rvalid (pMAX_OUTSTANDING = 4).
  - After 4 grants, m_req_o goes low.
  - One m_rvalid_i pulse → m_req_o is re-asserted in the same cycle, and the push plus pop keeps count at 4.
- reset_i pulsed with 2 transactions outstanding, then 2 m_rvalid_i pulses.
  - s_rvalid_o stays 0 and err_o goes 1 and stays 1 until the next reset.
- With BRIDGE_ARB_PERF_EN defined, run 3 grants for requester 0, 2 for requester 1 and 5 stall cycles.
  - perf_gnt0_o = 3, perf_gnt1_o = 2, perf_stall_o = 5.
  - perf_clr_i → all three counters read 0 on the next cycle.

Source files
------------

// File: rtl/bridge_obi_pkg.sv
// bridge_obi_pkg: shared constants and types for the two-requester OBI arbiter.
//   OBI_ADDR_W / OBI_DATA_W / OBI_BE_W : default OBI widths
//   NUM_REQ                            : number of requesters sharing the port
//   ID_W                               : width of a requester ID in the routing FIFO
//   obi_req_t / obi_rsp_t              : OBI address-phase / response-phase bundles
//   arb_state_e                        : arbiter lock state
package bridge_obi_pkg;
  localparam int OBI_ADDR_W = 32;
  localparam int OBI_DATA_W = 32;
  localparam int OBI_BE_W   = 4;
  localparam int NUM_REQ    = 2;
  localparam int ID_W       = $clog2(NUM_REQ);

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [OBI_BE_W-1:0]   be;
    logic [OBI_ADDR_W-1:0] addr;
    logic [OBI_DATA_W-1:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic                  gnt;
    logic                  rvalid;
    logic [OBI_DATA_W-1:0] rdata;
  } obi_rsp_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;
endpackage

// File: rtl/bridge_obi_arbiter_id_fifo.sv
// bridge_obi_id_fifo: small synchronous FIFO of requester IDs, used to route
// in-order OBI responses back to the requester that issued each transaction.
//   clk, reset_i        : clock, synchronous active-high reset (empties FIFO)
//   push_i, push_data_i : enqueue an ID (accepted when not full, or when a pop
//                         happens in the same cycle)
//   pop_i, head_o       : dequeue / oldest ID (pop ignored when empty)
//   full_o, empty_o     : status
//   count_o             : occupancy, 0..pDEPTH
// pDEPTH must be a power of two so the pointers wrap naturally.
module bridge_obi_id_fifo
  import bridge_obi_pkg::*;
#(
  parameter int pDEPTH = 4,
  parameter int pW     = ID_W,
  parameter int pCNT_W = $clog2(pDEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              push_i,
  input  logic [pW-1:0]     push_data_i,
  input  logic              pop_i,
  output logic [pW-1:0]     head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [pCNT_W-1:0] count_o
);
  localparam int PTR_W = $clog2(pDEPTH);

  logic [pDEPTH-1:0][pW-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [pCNT_W-1:0]         count_q, count_d;
  logic                      push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == pCNT_W'(pDEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // A pop frees a slot in the same cycle, so a push against a full FIFO is
  // accepted when accompanied by a pop.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/bridge_obi_arbiter.sv
// bridge_obi_arbiter: shares one OBI manager port between two requesters
// (0: USB register bridge, 1: host-side agent such as a dump/trace engine).
// Round-robin selection, address phase locked until granted, responses routed
// through an in-order ID FIFO allowing pMAX_OUTSTANDING transactions in flight.
//   clk, reset_i                    : heep_clk, synchronous active-high reset
//   s_req/we/be/addr/wdata_i [2]    : requester address phases
//   s_gnt_o, s_rvalid_o [2]         : per-requester grant / response valid
//   s_rdata_o                       : shared read data, qualified by s_rvalid_o
//   m_req/we/be/addr/wdata_o        : manager address phase to gr_heep_top
//   m_gnt_i, m_rvalid_i, m_rdata_i  : manager grant / response
//   busy_o                          : FIFO non-empty or request pending
//   err_o                           : sticky, response seen with nothing outstanding
// Optional macro BRIDGE_ARB_PERF_EN adds perf_clr_i and saturating 32-bit
// counters perf_gnt0_o, perf_gnt1_o (handshakes) and perf_stall_o (cycles
// with a request pending and no grant).
module bridge_obi_arbiter
  import bridge_obi_pkg::*;
#(
  parameter int pADDR_W          = OBI_ADDR_W,
  parameter int pDATA_W          = OBI_DATA_W,
  parameter int pMAX_OUTSTANDING = 4
) (
  input  logic                              clk,
  input  logic                              reset_i,
  input  logic [NUM_REQ-1:0]                s_req_i,
  input  logic [NUM_REQ-1:0]                s_we_i,
  input  logic [NUM_REQ-1:0][OBI_BE_W-1:0]  s_be_i,
  input  logic [NUM_REQ-1:0][pADDR_W-1:0]   s_addr_i,
  input  logic [NUM_REQ-1:0][pDATA_W-1:0]   s_wdata_i,
  output logic [NUM_REQ-1:0]                s_gnt_o,
  output logic [NUM_REQ-1:0]                s_rvalid_o,
  output logic [pDATA_W-1:0]                s_rdata_o,
  output logic                              m_req_o,
  output logic                              m_we_o,
  output logic [OBI_BE_W-1:0]               m_be_o,
  output logic [pADDR_W-1:0]                m_addr_o,
  output logic [pDATA_W-1:0]                m_wdata_o,
  input  logic                              m_gnt_i,
  input  logic                              m_rvalid_i,
  input  logic [pDATA_W-1:0]                m_rdata_i,
  output logic                              busy_o,
  output logic                              err_o
`ifdef BRIDGE_ARB_PERF_EN
  ,
  input  logic                              perf_clr_i,
  output logic [31:0]                       perf_gnt0_o,
  output logic [31:0]                       perf_gnt1_o,
  output logic [31:0]                       perf_stall_o
`endif
);
  localparam int CNT_W = $clog2(pMAX_OUTSTANDING) + 1;

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   sel_q, sel_d, sel;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic              err_q, err_d;
  logic [NUM_REQ-1:0] act;
  logic              fifo_full, fifo_empty, full_eff, pop, orphan, hs;
  logic [ID_W-1:0]   head;
  logic [CNT_W-1:0]  fifo_count;

  // Everything combinational is forced quiet while reset is held.
  assign act    = reset_i ? '0 : s_req_i;
  assign pop    = !reset_i && m_rvalid_i && !fifo_empty;
  assign orphan = !reset_i && m_rvalid_i && fifo_empty;
  // Full with a pop this cycle still has room for the push.
  assign full_eff = fifo_full && !pop;

  always_comb begin
    sel = '0;
    if (state_q == ARB_LOCKED)  sel = sel_q;
    else if (act == 2'b01)      sel = 1'b0;
    else if (act == 2'b10)      sel = 1'b1;
    else if (act == 2'b11)      sel = rr_q;
  end

  assign m_req_o   = act[sel] && !full_eff;
  assign hs        = m_req_o && m_gnt_i;
  assign m_we_o    = reset_i ? 1'b0 : s_we_i[sel];
  assign m_be_o    = reset_i ? '0   : s_be_i[sel];
  assign m_addr_o  = reset_i ? '0   : s_addr_i[sel];
  assign m_wdata_o = reset_i ? '0   : s_wdata_i[sel];
  assign s_rdata_o = reset_i ? '0   : m_rdata_i;
  assign busy_o    = !reset_i && ((fifo_count != '0) || m_req_o);
  assign err_o     = err_q && !reset_i;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_route
    assign s_gnt_o[i]    = hs  && (sel  == ID_W'(i));
    assign s_rvalid_o[i] = pop && (head == ID_W'(i));
  end

  always_comb begin
    state_d = (m_req_o && !m_gnt_i) ? ARB_LOCKED : ARB_IDLE;
    sel_d   = sel;
    rr_d    = hs ? ~sel : rr_q;
    err_d   = err_q | orphan;
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= ARB_IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

  bridge_obi_id_fifo #(
    .pDEPTH (pMAX_OUTSTANDING),
    .pW     (ID_W),
    .pCNT_W (CNT_W)
  ) u_fifo (
    .clk         (clk),
    .reset_i     (reset_i),
    .push_i      (hs),
    .push_data_i (sel),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

`ifdef BRIDGE_ARB_PERF_EN
  logic [31:0] perf_gnt0_q, perf_gnt0_d, perf_gnt1_q, perf_gnt1_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_gnt0_d  = perf_gnt0_q;
    perf_gnt1_d  = perf_gnt1_q;
    perf_stall_d = perf_stall_q;
    if (perf_clr_i) begin
      perf_gnt0_d  = '0;
      perf_gnt1_d  = '0;
      perf_stall_d = '0;
    end else begin
      if (s_gnt_o[0] && perf_gnt0_q != '1) perf_gnt0_d = perf_gnt0_q + 1'b1;
      if (s_gnt_o[1] && perf_gnt1_q != '1) perf_gnt1_d = perf_gnt1_q + 1'b1;
      if ((|act) && !(|s_gnt_o) && perf_stall_q != '1)
        perf_stall_d = perf_stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      perf_gnt0_q  <= '0;
      perf_gnt1_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_gnt0_q  <= perf_gnt0_d;
      perf_gnt1_q  <= perf_gnt1_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_gnt0_o  = perf_gnt0_q;
  assign perf_gnt1_o  = perf_gnt1_q;
  assign perf_stall_o = perf_stall_q;
`endif
endmodule

// File: tb/tb_bridge_obi_arbiter.sv
// Self-checking bench for bridge_obi_arbiter: directed scenarios plus a
// randomized run checked against a queue-based reference model.
module tb_bridge_obi_arbiter;
  import bridge_obi_pkg::*;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset_i;
  logic [1:0]        s_req_i, s_we_i, s_gnt_o, s_rvalid_o;
  logic [1:0][3:0]   s_be_i;
  logic [1:0][31:0]  s_addr_i, s_wdata_i;
  logic [31:0]       s_rdata_o, m_addr_o, m_wdata_o, m_rdata_i;
  logic              m_req_o, m_we_o, m_gnt_i, m_rvalid_i, busy_o, err_o;
  logic [3:0]        m_be_o;
`ifdef BRIDGE_ARB_PERF_EN
  logic              perf_clr_i;
  logic [31:0]       perf_gnt0_o, perf_gnt1_o, perf_stall_o;
`endif

  always #5 clk = ~clk;

  bridge_obi_arbiter #(.pADDR_W(32), .pDATA_W(32), .pMAX_OUTSTANDING(DEPTH)) dut (
    .clk(clk), .reset_i(reset_i),
    .s_req_i(s_req_i), .s_we_i(s_we_i), .s_be_i(s_be_i), .s_addr_i(s_addr_i),
    .s_wdata_i(s_wdata_i), .s_gnt_o(s_gnt_o), .s_rvalid_o(s_rvalid_o),
    .s_rdata_o(s_rdata_o), .m_req_o(m_req_o), .m_we_o(m_we_o), .m_be_o(m_be_o),
    .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o), .m_gnt_i(m_gnt_i),
    .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i), .busy_o(busy_o), .err_o(err_o)
`ifdef BRIDGE_ARB_PERF_EN
    , .perf_clr_i(perf_clr_i), .perf_gnt0_o(perf_gnt0_o),
    .perf_gnt1_o(perf_gnt1_o), .perf_stall_o(perf_stall_o)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: outstanding issuers in order, priority, lock, sticky error.
  int   mq[$];
  int   m_prio;
  bit   m_lock;
  int   m_lock_to;
  bit   m_err;
  int   e_sel;
  bit   e_mreq, e_pop, e_busy;
  logic [1:0] e_gnt, e_rv;

  function void model_reset();
    mq.delete(); m_prio = 0; m_lock = 0; m_lock_to = 0; m_err = 0;
  endfunction

  function void model_eval(logic [1:0] req, logic gnt, logic rv);
    e_pop = rv && (mq.size() != 0);
    if (m_lock)            e_sel = m_lock_to;
    else if (req == 2'b10) e_sel = 1;
    else if (req == 2'b11) e_sel = m_prio;
    else                   e_sel = 0;
    e_mreq = req[e_sel] && !(mq.size() == DEPTH && !e_pop);
    e_gnt  = (e_mreq && gnt) ? ((e_sel == 1) ? 2'b10 : 2'b01) : 2'b00;
    e_rv   = e_pop ? ((mq[0] == 1) ? 2'b10 : 2'b01) : 2'b00;
    e_busy = (mq.size() != 0) || e_mreq;
  endfunction

  function void model_commit(logic gnt, logic rv);
    if (e_pop) void'(mq.pop_front());
    if (rv && !e_pop) m_err = 1;
    if (e_mreq && gnt) begin mq.push_back(e_sel); m_prio = 1 - e_sel; end
    m_lock = e_mreq && !gnt;
    m_lock_to = e_sel;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    s_req_i = '0; s_we_i = '0; s_be_i = '0; s_addr_i = '0; s_wdata_i = '0;
    m_gnt_i = 0; m_rvalid_i = 0; m_rdata_i = '0;
`ifdef BRIDGE_ARB_PERF_EN
    perf_clr_i = 0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1; tick(); tick(); reset_i = 0;
    model_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_i = 1; s_req_i = 2'b11; s_addr_i[0] = 32'h44; m_gnt_i = 1;
    m_rvalid_i = 1; m_rdata_i = 32'h1234;
    tick(); #1;
    vectors++; if (m_req_o !== 1'b0) begin miscompares++; $display("FAIL rst_mreq got=%b exp=0", m_req_o); end
    vectors++; if (s_gnt_o !== 2'b00 || s_rvalid_o !== 2'b00) begin miscompares++; $display("FAIL rst_gnt_rv got=%b/%b exp=00/00", s_gnt_o, s_rvalid_o); end
    vectors++; if (s_rdata_o !== 32'h0 || m_addr_o !== 32'h0) begin miscompares++; $display("FAIL rst_data got=%h/%h exp=0/0", s_rdata_o, m_addr_o); end
    vectors++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin miscompares++; $display("FAIL rst_busy_err got=%b/%b exp=0/0", busy_o, err_o); end
    idle_inputs(); reset_i = 0; #1;
    vectors++; if (dut.u_fifo.count_o !== 3'd0 || busy_o !== 1'b0 || err_o !== 1'b0) begin miscompares++; $display("FAIL rst_release got cnt=%0d busy=%b err=%b exp 0/0/0", dut.u_fifo.count_o, busy_o, err_o); end
    model_reset();
  endtask

  task automatic test_single_write();
    do_reset();
    s_req_i = 2'b01; s_we_i = 2'b01; s_be_i[0] = 4'hF; s_addr_i[0] = 32'h0000_0100;
    s_wdata_i[0] = 32'hDEADBEEF; m_gnt_i = 1; #1;
    vectors++; if (m_req_o !== 1'b1 || s_gnt_o !== 2'b01) begin miscompares++; $display("FAIL single_hs got req=%b gnt=%b exp 1/01", m_req_o, s_gnt_o); end
    vectors++; if (m_addr_o !== 32'h100 || m_wdata_o !== 32'hDEADBEEF || m_we_o !== 1'b1 || m_be_o !== 4'hF) begin miscompares++; $display("FAIL single_addr got a=%h d=%h we=%b be=%h", m_addr_o, m_wdata_o, m_we_o, m_be_o); end
    tick(); s_req_i = 2'b00; m_gnt_i = 0; #1;
    vectors++; if (dut.u_fifo.count_o !== 3'd1 || busy_o !== 1'b1) begin miscompares++; $display("FAIL single_cnt got cnt=%0d busy=%b exp 1/1", dut.u_fifo.count_o, busy_o); end
    m_rvalid_i = 1; m_rdata_i = 32'h5A5A; #1;
    vectors++; if (s_rvalid_o !== 2'b01 || s_rdata_o !== 32'h5A5A) begin miscompares++; $display("FAIL single_rsp got rv=%b rd=%h exp 01/5a5a", s_rvalid_o, s_rdata_o); end
    tick(); m_rvalid_i = 0; #1;
    vectors++; if (busy_o !== 1'b0 || s_rvalid_o !== 2'b00) begin miscompares++; $display("FAIL single_idle got busy=%b rv=%b exp 0/00", busy_o, s_rvalid_o); end
  endtask

  task automatic test_round_robin();
    logic [1:0] eg, er;
    do_reset();
    s_addr_i[0] = 32'h1000; s_addr_i[1] = 32'h2000; m_gnt_i = 1;
    for (int c = 0; c < 9; c++) begin
      s_req_i = (c < 8) ? 2'b11 : 2'b00;
      m_rvalid_i = (c >= 1); m_rdata_i = 32'(c);
      #1;
      eg = (c < 8) ? (((c % 2) == 1) ? 2'b10 : 2'b01) : 2'b00;
      er = (c >= 1) ? ((((c - 1) % 2) == 1) ? 2'b10 : 2'b01) : 2'b00;
      vectors++; if (s_gnt_o !== eg) begin miscompares++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, s_gnt_o, eg); end
      if (c < 8) begin
        vectors++; if (m_addr_o !== ((c % 2 == 1) ? 32'h2000 : 32'h1000)) begin miscompares++; $display("FAIL rr_addr c=%0d got=%h", c, m_addr_o); end
      end
      if (c >= 1) begin
        vectors++; if (s_rvalid_o !== er || s_rdata_o !== 32'(c)) begin miscompares++; $display("FAIL rr_rsp c=%0d got=%b/%h exp=%b/%h", c, s_rvalid_o, s_rdata_o, er, c); end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_lock();
    do_reset();
    s_addr_i[0] = 32'hA0; s_addr_i[1] = 32'hB0;
    // First grant to requester 0 hands priority to requester 1.
    s_req_i = 2'b01; m_gnt_i = 1; tick();
    m_gnt_i = 0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) s_req_i = 2'b11;
      #1;
      vectors++; if (m_req_o !== 1'b1 || m_addr_o !== 32'hA0 || s_gnt_o !== 2'b00) begin miscompares++; $display("FAIL lock_hold c=%0d got req=%b a=%h gnt=%b exp 1/a0/00", c, m_req_o, m_addr_o, s_gnt_o); end
      tick();
    end
    m_gnt_i = 1; #1;
    vectors++; if (s_gnt_o !== 2'b01 || m_addr_o !== 32'hA0) begin miscompares++; $display("FAIL lock_release got gnt=%b a=%h exp 01/a0", s_gnt_o, m_addr_o); end
    tick(); #1;
    vectors++; if (s_gnt_o !== 2'b10 || m_addr_o !== 32'hB0) begin miscompares++; $display("FAIL lock_next got gnt=%b a=%h exp 10/b0", s_gnt_o, m_addr_o); end
    tick(); idle_inputs();
  endtask

  task automatic test_fifo_full();
    do_reset();
    s_req_i = 2'b01; m_gnt_i = 1;
    for (int c = 0; c < DEPTH; c++) begin
      #1;
      vectors++; if (s_gnt_o !== 2'b01) begin miscompares++; $display("FAIL full_fill c=%0d got=%b exp=01", c, s_gnt_o); end
      tick();
    end
    #1;
    vectors++; if (m_req_o !== 1'b0 || s_gnt_o !== 2'b00 || dut.u_fifo.count_o !== 3'd4) begin miscompares++; $display("FAIL full_block got req=%b gnt=%b cnt=%0d exp 0/00/4", m_req_o, s_gnt_o, dut.u_fifo.count_o); end
    m_rvalid_i = 1; #1;
    vectors++; if (m_req_o !== 1'b1 || s_gnt_o !== 2'b01 || s_rvalid_o !== 2'b01) begin miscompares++; $display("FAIL full_pushpop got req=%b gnt=%b rv=%b exp 1/01/01", m_req_o, s_gnt_o, s_rvalid_o); end
    tick(); m_rvalid_i = 0; #1;
    vectors++; if (dut.u_fifo.count_o !== 3'd4 || m_req_o !== 1'b0) begin miscompares++; $display("FAIL full_after got cnt=%0d req=%b exp 4/0", dut.u_fifo.count_o, m_req_o); end
    idle_inputs();
  endtask

  task automatic test_reset_outstanding();
    do_reset();
    s_req_i = 2'b11; m_gnt_i = 1; tick(); tick();
    idle_inputs(); reset_i = 1; tick(); reset_i = 0;
    for (int c = 0; c < 2; c++) begin
      m_rvalid_i = 1; m_rdata_i = 32'hBAD0 + 32'(c); #1;
      vectors++; if (s_rvalid_o !== 2'b00) begin miscompares++; $display("FAIL orphan_rv c=%0d got=%b exp=00", c, s_rvalid_o); end
      tick();
    end
    m_rvalid_i = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL orphan_err c=%0d got=%b exp=1", c, err_o); end
      tick();
    end
    do_reset(); #1;
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL err_clear got=%b exp=0", err_o); end
  endtask

`ifdef BRIDGE_ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    m_gnt_i = 1;
    for (int c = 0; c < 5; c++) begin
      s_req_i = (c < 4) ? 2'b11 : 2'b01;
      m_rvalid_i = (c >= 1);
      tick();
    end
    m_rvalid_i = 0; m_gnt_i = 0; s_req_i = 2'b01;
    for (int c = 0; c < 5; c++) tick();
    #1;
    vectors++; if (perf_gnt0_o !== 32'd3 || perf_gnt1_o !== 32'd2 || perf_stall_o !== 32'd5) begin miscompares++; $display("FAIL perf_cnt got=%0d/%0d/%0d exp=3/2/5", perf_gnt0_o, perf_gnt1_o, perf_stall_o); end
    perf_clr_i = 1; tick(); perf_clr_i = 0; #1;
    vectors++; if (perf_gnt0_o !== 32'd0 || perf_gnt1_o !== 32'd0 || perf_stall_o !== 32'd0) begin miscompares++; $display("FAIL perf_clr got=%0d/%0d/%0d exp=0/0/0", perf_gnt0_o, perf_gnt1_o, perf_stall_o); end
    idle_inputs();
  endtask
`endif

  task automatic test_random();
    bit pend[2];
    do_reset();
    pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1;
          s_addr_i[i]  = $urandom;
          s_wdata_i[i] = $urandom;
          s_we_i[i]    = 1'($urandom_range(1));
          s_be_i[i]    = 4'($urandom_range(15));
        end
      end
      s_req_i    = {pend[1], pend[0]};
      m_gnt_i    = ($urandom_range(2) != 0);
      m_rvalid_i = (mq.size() != 0) && ($urandom_range(2) != 0);
      m_rdata_i  = $urandom;
      #1;
      model_eval(s_req_i, m_gnt_i, m_rvalid_i);
      vectors++; if (m_req_o !== e_mreq || s_gnt_o !== e_gnt) begin miscompares++; $display("FAIL rnd_req c=%0d got req=%b gnt=%b exp %b/%b", c, m_req_o, s_gnt_o, e_mreq, e_gnt); end
      vectors++; if (s_rvalid_o !== e_rv || busy_o !== e_busy || err_o !== m_err) begin miscompares++; $display("FAIL rnd_rsp c=%0d got rv=%b busy=%b err=%b exp %b/%b/%b", c, s_rvalid_o, busy_o, err_o, e_rv, e_busy, m_err); end
      if (e_rv != 2'b00) begin
        vectors++; if (s_rdata_o !== m_rdata_i) begin miscompares++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, s_rdata_o, m_rdata_i); end
      end
      if (e_mreq) begin
        vectors++; if (m_addr_o !== s_addr_i[e_sel] || m_wdata_o !== s_wdata_i[e_sel] || m_we_o !== s_we_i[e_sel] || m_be_o !== s_be_i[e_sel]) begin miscompares++; $display("FAIL rnd_mux c=%0d got a=%h exp a=%h", c, m_addr_o, s_addr_i[e_sel]); end
      end
      model_commit(m_gnt_i, m_rvalid_i);
      if (e_gnt[0]) pend[0] = 0;
      if (e_gnt[1]) pend[1] = 0;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset_i = 1;
    test_reset();
    test_single_write();
    test_round_robin();
    test_lock();
    test_fifo_full();
    test_reset_outstanding();
`ifdef BRIDGE_ARB_PERF_EN
    test_perf();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
